// File: rtl/matmul_job_scheduler_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | matmul_job_scheduler_if : requester and engine signals of the job     |
// | scheduler; master = scheduler side, slave = environment side.         |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface matmul_job_scheduler_if #(
   parameter int NREQ  = 4,
   parameter int DIM_W = 5
);
   logic [NREQ-1:0]          req;
   logic [NREQ*4*DIM_W-1:0]  req_dims;
   logic [NREQ-1:0]          gnt;
   logic                     rsp_valid;
   logic                     rsp_err;
   logic [2:0]               rsp_id;
   logic                     busy;
   logic [2:0]               mm_src_id;
   logic                     mm_clear;
   logic                     mm_enable;
   logic [191:0]             mm_op_reg;
   logic                     mm_done;

   modport master (
      input  req, req_dims, mm_done,
      output gnt, rsp_valid, rsp_err, rsp_id, busy,
             mm_src_id, mm_clear, mm_enable, mm_op_reg
   );

   modport slave (
      output req, req_dims, mm_done,
      input  gnt, rsp_valid, rsp_err, rsp_id, busy,
             mm_src_id, mm_clear, mm_enable, mm_op_reg
   );
endinterface
`default_nettype wire

// File: rtl/matmul_job_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | matmul_job_scheduler : round-robin sharing of one matrix engine,      |
// | with dimension checking, clear/launch sequencing and done timeout.    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module matmul_job_scheduler #(
   parameter int NREQ    = 4,
   parameter int DIM_W   = 5,
   parameter int MAX_DIM = 15,
   parameter int TIMEOUT = 8191
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   matmul_job_scheduler_if.master     bus
);
   localparam int JOB_W = 4 * DIM_W;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_LAUNCH  = 3'd2,
      ST_WAIT_LO = 3'd3,
      ST_WAIT_HI = 3'd4,
      ST_RESP    = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         ptr_q, ptr_d;
   logic [2:0]         id_q, id_d;
   logic               err_q, err_d;
   logic               loaded_q, loaded_d;
   logic [JOB_W-1:0]   dims_q, dims_d;
   logic [CNT_W-1:0]   tmo_q, tmo_d;

   logic [7:0]         req_ext;
   logic [8*JOB_W-1:0] dims_ext;
   logic [3:0]         slot;
   logic               found;
   logic [2:0]         winner;
   logic [JOB_W-1:0]   win_dims;
   logic               legal;
   logic               accept;
   logic [7:0]         gnt_full;
   logic               clear_w, enable_w, go_w, rsp_w;

   function automatic logic in_range(input logic [DIM_W-1:0] v);
      return (v != '0) && (int'(v) <= MAX_DIM);
   endfunction

   assign req_ext  = 8'(bus.req);
   assign dims_ext = (8*JOB_W)'(bus.req_dims);

   // First pending request at or after the pointer, wrapping at NREQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      slot   = '0;
      for (int k = 0; k < NREQ; k++) begin
         slot = {1'b0, ptr_q} + 4'(k);
         if (slot >= 4'(NREQ)) slot = slot - 4'(NREQ);
         if (!found && req_ext[slot[2:0]]) begin
            found  = 1'b1;
            winner = slot[2:0];
         end
      end
   end

   assign win_dims = dims_ext[int'(winner)*JOB_W +: JOB_W];
   assign legal    = in_range(win_dims[DIM_W-1:0])
                   && in_range(win_dims[2*DIM_W-1:DIM_W])
                   && in_range(win_dims[3*DIM_W-1:2*DIM_W])
                   && in_range(win_dims[4*DIM_W-1:3*DIM_W])
                   && (win_dims[2*DIM_W-1:DIM_W] == win_dims[3*DIM_W-1:2*DIM_W]);
   // Gating with reset keeps the combinational grant at 0 while reset is held.
   assign accept   = (state_q == ST_IDLE) && found && reset;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      id_d     = id_q;
      err_d    = err_q;
      loaded_d = loaded_q;
      dims_d   = dims_q;
      tmo_d    = tmo_q;
      gnt_full = '0;
      clear_w  = 1'b0;
      enable_w = 1'b0;
      go_w     = 1'b0;
      rsp_w    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               gnt_full = 8'd1 << winner;
               id_d     = winner;
               if (legal) begin
                  dims_d   = win_dims;
                  loaded_d = 1'b1;
                  err_d    = 1'b0;
                  state_d  = ST_CLEAR;
               end else begin
                  err_d    = 1'b1;
                  state_d  = ST_RESP;
               end
            end
         end
         ST_CLEAR: begin
            clear_w = 1'b1;
            state_d = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            enable_w = 1'b1;
            go_w     = 1'b1;
            tmo_d    = '0;
            state_d  = ST_WAIT_LO;
         end
         ST_WAIT_LO, ST_WAIT_HI: begin
            tmo_d = tmo_q + 1'b1;
            if (state_q == ST_WAIT_LO && !bus.mm_done) begin
               state_d = ST_WAIT_HI;
            end else if (state_q == ST_WAIT_HI && bus.mm_done) begin
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_w   = 1'b1;
            ptr_d   = (id_q == 3'(NREQ - 1)) ? 3'd0 : id_q + 3'd1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         id_q     <= '0;
         err_q    <= 1'b0;
         loaded_q <= 1'b0;
         dims_q   <= '0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         err_q    <= err_d;
         loaded_q <= loaded_d;
         dims_q   <= dims_d;
         tmo_q    <= tmo_d;
      end
   end

   assign bus.gnt       = gnt_full[NREQ-1:0];
   assign bus.rsp_valid = rsp_w;
   assign bus.rsp_err   = rsp_w & err_q;
   assign bus.rsp_id    = id_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.mm_src_id = id_q;
   assign bus.mm_clear  = clear_w;
   assign bus.mm_enable = enable_w;
   // Words from MSB: go, hB, wB, hA, wA, opcode.
   assign bus.mm_op_reg = {31'd0, go_w,
                           32'(dims_q[4*DIM_W-1:3*DIM_W]),
                           32'(dims_q[3*DIM_W-1:2*DIM_W]),
                           32'(dims_q[2*DIM_W-1:DIM_W]),
                           32'(dims_q[DIM_W-1:0]),
                           31'd0, loaded_q};
endmodule
`default_nettype wire

// File: tb/tb_matmul_job_scheduler.sv
`default_nettype none
// Scoreboard bench for matmul_job_scheduler with a behavioural engine model.
module tb_matmul_job_scheduler;
   localparam int NREQ    = 4;
   localparam int DIM_W   = 5;
   localparam int MAX_DIM = 15;
   localparam int TIMEOUT = 8191;
   localparam int JOB_W   = 4 * DIM_W;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   matmul_job_scheduler_if #(.NREQ(NREQ), .DIM_W(DIM_W)) bus ();

   matmul_job_scheduler #(
      .NREQ(NREQ), .DIM_W(DIM_W), .MAX_DIM(MAX_DIM), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int     id;
      bit     err;
      bit     tmo;
      int     gcyc;
      longint csum;
      int     wa, ha, wb, hb;
   } exp_t;

   exp_t            sb[$];
   int              n_checks = 0;
   int              n_fail   = 0;
   int              cyc      = 0;
   int              ptr_m    = 0;
   int              g_cnt    = 0;
   int              rsp_cnt  = 0;
   int              n_clr    = 0;
   int              n_en     = 0;
   int              wlo_cyc  = 0;
   int              rise_cyc = 0;
   bit              prev_done = 1'b1;
   bit              hold     = 1'b0;
   bit              hang_m   = 1'b0;
   int              run_len_m = 3;
   logic [NREQ-1:0] gnt_last = '0;

   task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int opa(int s, int i, int k);
      return ((s * 5 + i * 3 + k * 7) % 9) - 4;
   endfunction
   function automatic int opb(int s, int k, int j);
      return ((s * 3 + k * 2 + j * 5) % 7) - 3;
   endfunction
   function automatic longint ref_csum(int s, int wa, int ha, int wb);
      longint acc = 0;
      for (int i = 0; i < ha; i++)
         for (int j = 0; j < wb; j++) begin
            longint dot = 0;
            for (int k = 0; k < wa; k++) dot += longint'(opa(s, i, k) * opb(s, k, j));
            acc += dot * longint'(i * 15 + j + 1);
         end
      return acc;
   endfunction
   function automatic bit legal_dims(int wa, int ha, int wb, int hb);
      return wa >= 1 && wa <= MAX_DIM && ha >= 1 && ha <= MAX_DIM &&
             wb >= 1 && wb <= MAX_DIM && hb >= 1 && hb <= MAX_DIM && ha == wb;
   endfunction

   // Engine model: C accumulates A*B on each run; only mm_clear zeroes it.
   int   c_m [0:14][0:14];
   logic done_m = 1'b1;
   bit   running = 1'b0;
   int   run_left = 0;
   int   e_src = 0, e_wa = 0, e_ha = 0, e_wb = 0;
   assign bus.mm_done = done_m;

   function automatic longint csum_c(int ha, int wb);
      longint acc = 0;
      for (int i = 0; i < ha; i++)
         for (int j = 0; j < wb; j++) acc += longint'(c_m[i][j]) * longint'(i * 15 + j + 1);
      return acc;
   endfunction

   always @(posedge clk) begin
      if (bus.mm_clear) begin
         for (int i = 0; i < 15; i++)
            for (int j = 0; j < 15; j++) c_m[i][j] = 0;
         running <= 1'b0;
         done_m  <= 1'b1;
      end else if (bus.mm_enable) begin
         e_src    <= int'(bus.mm_src_id);
         e_wa     <= int'(bus.mm_op_reg[32 +: 32]);
         e_ha     <= int'(bus.mm_op_reg[64 +: 32]);
         e_wb     <= int'(bus.mm_op_reg[96 +: 32]);
         running  <= 1'b1;
         run_left <= run_len_m;
         done_m   <= 1'b0;
      end else if (running && !hang_m) begin
         if (run_left == 0) begin
            for (int i = 0; i < e_ha; i++)
               for (int j = 0; j < e_wb; j++)
                  for (int k = 0; k < e_wa; k++)
                     c_m[i][j] = c_m[i][j] + opa(e_src, i, k) * opb(e_src, k, j);
            running <= 1'b0;
            done_m  <= 1'b1;
         end else begin
            run_left <= run_left - 1;
         end
      end
   end

   // Monitor: predicts the RR winner, pushes expectations on gnt, checks on rsp_valid.
   always @(negedge clk) begin
      exp_t e;
      int   w;
      logic [JOB_W-1:0] d;
      logic [191:0] op;
      cyc++;
      gnt_last = reset ? bus.gnt : '0;
      if (!reset) begin
         sb.delete();
         ptr_m     = 0;
         prev_done = bus.mm_done;
      end else begin
         if (bus.mm_clear) n_clr++;
         if (bus.mm_enable) begin
            n_en++;
            wlo_cyc = cyc + 1;
            if (sb.size() > 0) begin
               op = '0;
               op[0]        = 1'b1;
               op[32 +: 32] = 32'(sb[0].wa);
               op[64 +: 32] = 32'(sb[0].ha);
               op[96 +: 32] = 32'(sb[0].wb);
               op[128 +: 32] = 32'(sb[0].hb);
               op[160]      = 1'b1;
               check("launch_op_reg", bus.mm_op_reg, op);
               check("launch_src_id", 192'(bus.mm_src_id), 192'(sb[0].id));
            end
         end
         if (!prev_done && bus.mm_done) rise_cyc = cyc;
         prev_done = bus.mm_done;
         if (|bus.gnt) begin
            g_cnt++;
            w = -1;
            for (int k = 0; k < NREQ; k++)
               if (w < 0 && bus.req[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
            check("gnt_winner", 192'(bus.gnt), (w < 0) ? 192'd0 : (192'd1 << w));
            check("gnt_after_rsp", 192'(sb.size()), 192'd0);
            if (w >= 0) begin
               d      = bus.req_dims[w * JOB_W +: JOB_W];
               e.id   = w;
               e.wa   = int'(d[4:0]);
               e.ha   = int'(d[9:5]);
               e.wb   = int'(d[14:10]);
               e.hb   = int'(d[19:15]);
               e.tmo  = legal_dims(e.wa, e.ha, e.wb, e.hb) && hang_m;
               e.err  = !legal_dims(e.wa, e.ha, e.wb, e.hb) || hang_m;
               e.gcyc = cyc;
               e.csum = e.err ? 0 : ref_csum(w, e.wa, e.ha, e.wb);
               n_clr  = 0;
               n_en   = 0;
               sb.push_back(e);
            end
         end
         if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
               check("rsp_unexpected", 192'd1, 192'd0);
            end else begin
               e = sb.pop_front();
               rsp_cnt++;
               check("rsp_id", 192'(bus.rsp_id), 192'(e.id));
               check("rsp_err", 192'(bus.rsp_err), 192'(e.err));
               ptr_m = (e.id + 1) % NREQ;
               if (e.tmo) begin
                  check("timeout_cycles", 192'(cyc - wlo_cyc), 192'(TIMEOUT));
               end else if (e.err) begin
                  check("reject_latency", 192'(cyc - e.gcyc), 192'd1);
                  check("reject_no_clear", 192'(n_clr), 192'd0);
                  check("reject_no_enable", 192'(n_en), 192'd0);
               end else begin
                  check("ok_latency", 192'(cyc - rise_cyc), 192'd1);
                  check("ok_one_clear", 192'(n_clr), 192'd1);
                  check("ok_one_enable", 192'(n_en), 192'd1);
                  check("c_product", 192'(csum_c(e.ha, e.wb)), 192'(e.csum));
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (!hold) bus.req = bus.req & ~gnt_last;
   endtask

   task automatic set_dims(input int r, input int wa, input int ha, input int wb, input int hb);
      bus.req_dims[r * JOB_W +: JOB_W] = {DIM_W'(hb), DIM_W'(wb), DIM_W'(ha), DIM_W'(wa)};
   endtask

   task automatic wait_rsp(input int n, input int budget);
      int target = rsp_cnt + n;
      int left   = budget;
      while (rsp_cnt < target && left > 0) begin
         tick();
         left--;
      end
      if (rsp_cnt < target) check("wait_rsp_timeout", 192'(rsp_cnt), 192'(target));
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt"},       192'(bus.gnt),       192'd0);
      check({tag, "_rsp_valid"}, 192'(bus.rsp_valid), 192'd0);
      check({tag, "_rsp_err"},   192'(bus.rsp_err),   192'd0);
      check({tag, "_rsp_id"},    192'(bus.rsp_id),    192'd0);
      check({tag, "_busy"},      192'(bus.busy),      192'd0);
      check({tag, "_src_id"},    192'(bus.mm_src_id), 192'd0);
      check({tag, "_clear"},     192'(bus.mm_clear),  192'd0);
      check({tag, "_enable"},    192'(bus.mm_enable), 192'd0);
      check({tag, "_op_reg"},    bus.mm_op_reg,       192'd0);
   endtask

   initial begin
      int gbase;
      int left;
      bus.req      = '0;
      bus.req_dims = '0;
      set_dims(0, 2, 2, 2, 2);
      bus.req = 4'b0001;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b1;

      // Single legal 2x2 job.
      wait_rsp(1, 200);

      // Rejections on requester 2: hA!=wB, wA=0, hB=16.
      set_dims(2, 4, 3, 4, 4);
      bus.req = 4'b0100;
      wait_rsp(1, 50);
      set_dims(2, 0, 3, 3, 3);
      bus.req = 4'b0100;
      wait_rsp(1, 50);
      set_dims(2, 3, 3, 3, 16);
      bus.req = 4'b0100;
      wait_rsp(1, 50);

      // Requester 3 job returns the pointer to 0.
      set_dims(3, 15, 6, 6, 15);
      bus.req = 4'b1000;
      wait_rsp(1, 200);

      // All requesters held: grants 0,1,2,3,0.
      set_dims(0, 3, 4, 4, 2);
      set_dims(1, 5, 2, 2, 7);
      set_dims(2, 1, 1, 1, 1);
      hold    = 1'b1;
      bus.req = 4'b1111;
      gbase   = g_cnt;
      left    = 500;
      while (g_cnt < gbase + 5 && left > 0) begin
         tick();
         left--;
      end
      check("rr_grant_count", 192'(g_cnt - gbase), 192'd5);
      bus.req = '0;
      hold    = 1'b0;
      wait_rsp(1, 200);

      // Engine never finishes: timeout, then a normal job recovers.
      hang_m = 1'b1;
      bus.req = 4'b0010;
      wait_rsp(1, TIMEOUT + 100);
      hang_m = 1'b0;
      bus.req = 4'b0010;
      wait_rsp(1, 200);

      // Reset while waiting on the engine abandons the job.
      run_len_m = 30;
      set_dims(2, 4, 4, 4, 4);
      bus.req = 4'b0100;
      left = 50;
      while (!bus.mm_enable && left > 0) begin
         tick();
         left--;
      end
      repeat (5) tick();
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("midjob_reset");
      run_len_m = 3;
      set_dims(1, 3, 5, 5, 2);
      set_dims(3, 2, 4, 4, 6);
      bus.req = 4'b1010;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      wait_rsp(2, 300);

      // Full-size job twice: second result must not include the first.
      set_dims(0, 15, 15, 15, 15);
      bus.req = 4'b0001;
      wait_rsp(1, 300);
      bus.req = 4'b0001;
      wait_rsp(1, 300);

      repeat (5) tick();
      check("sb_drained", 192'(sb.size()), 192'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
